// File: rtl/ex_arbiter_pkg.sv
// Shared definitions for the commit-stage exception arbiter.
// Holds the exception codes, the wb_ex flag layout and the event-priority helpers.
package ex_arbiter_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_ERTN = 6'h3E;

    localparam logic ESUBCODE_ADEF = 1'b0;

    localparam int WB_EX_ADEF = 0;
    localparam int WB_EX_INE  = 1;
    localparam int WB_EX_SYS  = 2;
    localparam int WB_EX_BRK  = 3;
    localparam int WB_EX_ALE  = 4;
    localparam int WB_EX_ERTN = 5;
    localparam int WB_EX_W    = 6;

    localparam int HW_INT_W = 8;
    localparam int INT_W    = 13;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_INT,
        EV_ADEF,
        EV_INE,
        EV_SYS,
        EV_BRK,
        EV_ALE,
        EV_ERTN
    } ex_event_e;

    // Earlier branches win: interrupts pre-empt every synchronous exception.
    function automatic ex_event_e pick_event(input logic int_pend,
                                             input logic [WB_EX_W-1:0] wb_ex);
        ex_event_e ev;
        if (int_pend)                 ev = EV_INT;
        else if (wb_ex[WB_EX_ADEF])   ev = EV_ADEF;
        else if (wb_ex[WB_EX_INE])    ev = EV_INE;
        else if (wb_ex[WB_EX_SYS])    ev = EV_SYS;
        else if (wb_ex[WB_EX_BRK])    ev = EV_BRK;
        else if (wb_ex[WB_EX_ALE])    ev = EV_ALE;
        else if (wb_ex[WB_EX_ERTN])   ev = EV_ERTN;
        else                          ev = EV_NONE;
        return ev;
    endfunction

    function automatic logic [5:0] event_ecode(input ex_event_e ev);
        logic [5:0] code;
        case (ev)
            EV_INT:  code = ECODE_INT;
            EV_ADEF: code = ECODE_ADEF;
            EV_INE:  code = ECODE_INE;
            EV_SYS:  code = ECODE_SYS;
            EV_BRK:  code = ECODE_BRK;
            EV_ALE:  code = ECODE_ALE;
            EV_ERTN: code = ECODE_ERTN;
            default: code = 6'h00;
        endcase
        return code;
    endfunction

    function automatic logic event_esubcode(input ex_event_e ev);
        logic sub;
        case (ev)
            EV_ADEF: sub = ESUBCODE_ADEF;
            default: sub = 1'b0;
        endcase
        return sub;
    endfunction

endpackage

// File: rtl/ex_arbiter_int_sync.sv
// Multi-flop vector synchronizer for the asynchronous external interrupt lines.
// Every stage clears on the synchronous active-low reset.
module int_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [DEPTH];
    logic [WIDTH-1:0] sync_d [DEPTH];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/ex_arbiter.sv
// Commit-stage exception/interrupt arbiter: picks the highest-priority event,
// drives the CSR exception inputs, then sequences flush and fetch redirect.
module ex_arbiter
    import ex_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wb_valid,
    input  logic [31:0]         wb_pc,
    input  logic [WB_EX_W-1:0]  wb_ex,
    input  logic [31:0]         wb_vaddr,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                timer_int,
    input  logic                csr_crmd_ie,
    input  logic [INT_W-1:0]    csr_ecfg_lie,
    input  logic [1:0]          csr_estat_sw,
    output logic [HW_INT_W-1:0] hw_is,
    output logic                ex_en,
    output logic [5:0]          ecode,
    output logic                esubcode,
    output logic [31:0]         ex_pc,
    output logic [31:0]         ex_vaddr,
    output logic                wb_commit,
    output logic                flush,
    output logic                redirect_valid,
    output logic                redirect_sel,
    input  logic                redirect_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIR
    } state_e;

    state_e      state_q, state_d;
    logic        ex_en_q, ex_en_d;
    logic [5:0]  ecode_q, ecode_d;
    logic        esubcode_q, esubcode_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_vaddr_q, ex_vaddr_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        redirect_sel_q, redirect_sel_d;

    logic [INT_W-1:0] is_vec;
    logic             int_pend;
    logic             evaluate;
    ex_event_e        ev;
    logic             take;

    int_sync #(
        .WIDTH (HW_INT_W),
        .DEPTH (SYNC_STAGES)
    ) u_int_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (hw_int),
        .q    (hw_is)
    );

    // Bit 12 is the IPI slot and bit 10 is reserved; neither has a source here.
    assign is_vec   = {1'b0, timer_int, 1'b0, hw_is, csr_estat_sw};
    assign int_pend = csr_crmd_ie & (|(is_vec & csr_ecfg_lie));
    assign evaluate = (state_q == ST_IDLE) & wb_valid;

    always_comb begin
        ev = EV_NONE;
        if (evaluate) begin
            ev = pick_event(int_pend, wb_ex);
        end
    end

    assign take      = (ev != EV_NONE);
    assign wb_commit = evaluate & ~take;

    always_comb begin
        state_d          = state_q;
        ex_en_d          = 1'b0;
        ecode_d          = 6'h00;
        esubcode_d       = 1'b0;
        ex_pc_d          = ex_pc_q;
        ex_vaddr_d       = ex_vaddr_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_sel_d   = redirect_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d        = ST_FLUSH;
                    flush_d        = 1'b1;
                    ex_en_d        = (ev != EV_ERTN);
                    ecode_d        = event_ecode(ev);
                    esubcode_d     = event_esubcode(ev);
                    ex_pc_d        = wb_pc;
                    redirect_sel_d = (ev == EV_ERTN);
                    case (ev)
                        EV_ADEF: ex_vaddr_d = wb_pc;
                        EV_ALE:  ex_vaddr_d = wb_vaddr;
                        default: ex_vaddr_d = 32'h0;
                    endcase
                end
            end
            ST_FLUSH: begin
                state_d          = ST_REDIR;
                redirect_valid_d = 1'b1;
            end
            ST_REDIR: begin
                // redirect_sel stays frozen until fetch takes the request.
                if (redirect_valid_q && redirect_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    redirect_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            ex_en_q          <= 1'b0;
            ecode_q          <= 6'h00;
            esubcode_q       <= 1'b0;
            ex_pc_q          <= 32'h0;
            ex_vaddr_q       <= 32'h0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_sel_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            ex_en_q          <= ex_en_d;
            ecode_q          <= ecode_d;
            esubcode_q       <= esubcode_d;
            ex_pc_q          <= ex_pc_d;
            ex_vaddr_q       <= ex_vaddr_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_sel_q   <= redirect_sel_d;
        end
    end

    assign ex_en          = ex_en_q;
    assign ecode          = ecode_q;
    assign esubcode       = esubcode_q;
    assign ex_pc          = ex_pc_q;
    assign ex_vaddr       = ex_vaddr_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_sel   = redirect_sel_q;

endmodule
